// File: rtl/data_cache_pkg.sv
// Shared types and width helpers for the direct-mapped write-through data cache.
package data_cache_pkg;

  typedef enum logic {IDLE, REFILL} state_t;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  function automatic int tag_width(input int addr_len, input int index_bits);
    return addr_len - index_bits - 2;
  endfunction

  function automatic int line_count(input int index_bits);
    return 1 << index_bits;
  endfunction

endpackage

// File: rtl/data_cache_if.sv
// Pipeline-side and RAM-side bus of the data cache; master is the environment, slave the cache.
interface data_cache_if #(parameter int ADDRESS_LENGTH = 32) ();
  logic                      re;
  logic [1:0]                ld_size;
  logic                      sw;
  logic                      sh;
  logic                      sb;
  logic [ADDRESS_LENGTH-1:0] a;
  logic [ADDRESS_LENGTH-1:0] wd;
  logic [ADDRESS_LENGTH-1:0] rd;
  logic                      stall;
  logic [ADDRESS_LENGTH-1:0] mem_a;
  logic [ADDRESS_LENGTH-1:0] mem_wd;
  logic                      mem_sw;
  logic                      mem_sh;
  logic                      mem_sb;
  logic [ADDRESS_LENGTH-1:0] mem_rd;

  modport master (
    output re, ld_size, sw, sh, sb, a, wd, mem_rd,
    input  rd, stall, mem_a, mem_wd, mem_sw, mem_sh, mem_sb
  );

  modport slave (
    input  re, ld_size, sw, sh, sb, a, wd, mem_rd,
    output rd, stall, mem_a, mem_wd, mem_sw, mem_sh, mem_sb
  );
endinterface

// File: rtl/data_cache_store.sv
// Line storage: valid bits (reset), tags and byte-writable data words (not reset).
module data_cache_store #(
  parameter int DATA_W     = 32,
  parameter int INDEX_BITS = 3,
  parameter int TAG_W      = 27
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic                  rd_valid,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [DATA_W-1:0]     rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic                  inv_en,
  input  logic [INDEX_BITS-1:0] inv_idx
);
  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tags  [LINES];
  logic [DATA_W-1:0] words [LINES];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else begin
      if (wr_en)  valid[wr_idx]  <= 1'b1;
      if (inv_en) valid[inv_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_idx] <= wr_tag;
      for (int b = 0; b < DATA_W/8; b++) begin
        if (wr_be[b]) words[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_data  = words[rd_idx];
endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word refill.
// Optional hit/miss counters are built only when DATA_CACHE_STATS_EN is defined.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int ADDRESS_LENGTH = 32,
  parameter int INDEX_BITS     = 3
) (
  input  logic        clk,
  input  logic        rst,
  data_cache_if.slave bus,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  localparam int TAG_W = tag_width(ADDRESS_LENGTH, INDEX_BITS);
  localparam int BE_W  = ADDRESS_LENGTH / 8;

  state_t                    state, state_nxt;
  logic [1:0]                off;
  logic [INDEX_BITS-1:0]     idx;
  logic [TAG_W-1:0]          tag;
  logic                      line_valid;
  logic [TAG_W-1:0]          line_tag;
  logic [ADDRESS_LENGTH-1:0] line_data;
  logic                      line_hit, store, crossing, misaligned;
  logic [3:0]                ld_bytes;
  logic [BE_W-1:0]           st_be, wr_be;
  logic [ADDRESS_LENGTH-1:0] st_data, wr_data;
  logic                      wr_en, inv_en;

  assign off      = bus.a[1:0];
  assign idx      = bus.a[INDEX_BITS+1:2];
  assign tag      = bus.a[ADDRESS_LENGTH-1:INDEX_BITS+2];
  assign line_hit = line_valid && (line_tag == tag);
  assign store    = bus.sw || bus.sh || bus.sb;

  always_comb begin
    case (bus.ld_size)
      SIZE_B:  ld_bytes = 4'd1;
      SIZE_H:  ld_bytes = 4'd2;
      default: ld_bytes = 4'd4;
    endcase
  end
  assign crossing = ({2'b00, off} + ld_bytes) > 4'd4;

  // Store lane placement; a misaligned store that hits drops the line instead.
  always_comb begin
    st_be      = '0;
    misaligned = 1'b0;
    st_data    = bus.wd << {off, 3'b000};
    if (bus.sw) begin
      misaligned = (off != 2'b00);
      st_be      = '1;
    end else if (bus.sh) begin
      misaligned = off[0];
      st_be      = BE_W'(2'b11) << off;
    end else if (bus.sb) begin
      st_be      = BE_W'(1'b1) << off;
    end
  end

  data_cache_store #(
    .DATA_W(ADDRESS_LENGTH), .INDEX_BITS(INDEX_BITS), .TAG_W(TAG_W)
  ) u_store (
    .clk(clk), .rst(rst),
    .rd_idx(idx), .rd_valid(line_valid), .rd_tag(line_tag), .rd_data(line_data),
    .wr_en(wr_en), .wr_idx(idx), .wr_tag(tag), .wr_data(wr_data), .wr_be(wr_be),
    .inv_en(inv_en), .inv_idx(idx)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    bus.stall  = 1'b0;
    bus.rd     = '0;
    bus.mem_a  = bus.a;
    bus.mem_wd = bus.wd;
    bus.mem_sw = 1'b0;
    bus.mem_sh = 1'b0;
    bus.mem_sb = 1'b0;
    wr_en      = 1'b0;
    wr_be      = st_be;
    wr_data    = st_data;
    inv_en     = 1'b0;
    case (state)
      IDLE: begin
        if (store) begin
          bus.mem_sw = bus.sw;
          bus.mem_sh = bus.sh && !bus.sw;
          bus.mem_sb = bus.sb && !bus.sw && !bus.sh;
          if (line_hit) begin
            inv_en = misaligned;
            wr_en  = !misaligned;
          end
        end else if (bus.re) begin
          if (crossing) begin
            bus.rd = bus.mem_rd;
          end else if (line_hit) begin
            bus.rd = line_data >> {off, 3'b000};
          end else begin
            bus.stall = 1'b1;
            state_nxt = REFILL;
          end
        end
      end
      REFILL: begin
        bus.mem_a = {bus.a[ADDRESS_LENGTH-1:2], 2'b00};
        bus.stall = 1'b1;
        wr_en     = 1'b1;
        wr_be     = '1;
        wr_data   = bus.mem_rd;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Reset overrides everything, including an in-flight refill write.
    if (rst) begin
      state_nxt  = IDLE;
      bus.stall  = 1'b0;
      bus.rd     = '0;
      bus.mem_sw = 1'b0;
      bus.mem_sh = 1'b0;
      bus.mem_sb = 1'b0;
      wr_en      = 1'b0;
      inv_en     = 1'b0;
    end
  end

`ifdef DATA_CACHE_STATS_EN
  logic [31:0] hits, misses;
  logic        lookup;

  assign lookup = (state == IDLE) && !store && bus.re && !crossing;

  always_ff @(posedge clk) begin
    if (rst) begin
      hits   <= '0;
      misses <= '0;
    end else begin
      if (lookup && line_hit)  hits   <= hits + 32'd1;
      if (lookup && !line_hit) misses <= misses + 32'd1;
    end
  end

  assign hit_count  = hits;
  assign miss_count = misses;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif
endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache: byte RAM model plus a valid/tag shadow predicting stalls.
module tb_data_cache;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] hit_count, miss_count;

  data_cache_if #(.ADDRESS_LENGTH(32)) bus ();

  data_cache #(.ADDRESS_LENGTH(32), .INDEX_BITS(3)) dut (
    .clk(clk), .rst(rst), .bus(bus), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] rd;
    int          stalls;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [7:0]  ram [256];
  logic        mv [8];
  logic [26:0] mt [8];
  int          exp_hit = 0;
  int          exp_miss = 0;

  // RAM window covers 0x10000..0x100FF, indexed by the low address byte.
  logic [7:0] ma;
  assign ma = bus.mem_a[7:0];
  assign bus.mem_rd = {ram[8'(ma + 8'd3)], ram[8'(ma + 8'd2)], ram[8'(ma + 8'd1)], ram[ma]};

  always @(posedge clk) begin
    if (bus.mem_sw) begin
      for (int i = 0; i < 4; i++) ram[8'(ma + 8'(i))] = bus.mem_wd[8*i +: 8];
    end else if (bus.mem_sh) begin
      for (int i = 0; i < 2; i++) ram[8'(ma + 8'(i))] = bus.mem_wd[8*i +: 8];
    end else if (bus.mem_sb) begin
      ram[ma] = bus.mem_wd[7:0];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ram_bytes(input logic [7:0] base);
    return {ram[8'(base + 8'd3)], ram[8'(base + 8'd2)], ram[8'(base + 8'd1)], ram[base]};
  endfunction

  function automatic int size_bytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  task automatic check_counters(input string tag);
`ifdef DATA_CACHE_STATS_EN
    check({tag, "_hits"}, hit_count, 32'(exp_hit));
    check({tag, "_misses"}, miss_count, 32'(exp_miss));
`else
    check({tag, "_hits"}, hit_count, 32'd0);
    check({tag, "_misses"}, miss_count, 32'd0);
`endif
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) mv[i] = 1'b0;
    exp_hit  = 0;
    exp_miss = 0;
  endtask

  // Called just after a rising edge; returns just after the edge that retires the load.
  task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] sz);
    exp_t        e;
    exp_t        got;
    int          n;
    logic [2:0]  i;
    logic [26:0] t;
    logic [1:0]  o;
    i = addr[4:2];
    t = addr[31:5];
    o = addr[1:0];
    e.tag = tag;
    if (int'(o) + size_bytes(sz) > 4) begin
      e.rd     = ram_bytes(addr[7:0]);
      e.stalls = 0;
    end else begin
      e.rd     = ram_bytes({addr[7:2], 2'b00}) >> (8 * int'(o));
      e.stalls = (mv[i] && mt[i] == t) ? 0 : 2;
      if (e.stalls != 0) exp_miss++;
      exp_hit++;
      mv[i] = 1'b1;
      mt[i] = t;
    end
    exp_q.push_back(e);
    bus.re      = 1'b1;
    bus.a       = addr;
    bus.ld_size = sz;
    n = 0;
    @(negedge clk);
    while (bus.stall && n < 8) begin
      n++;
      @(negedge clk);
    end
    got.rd     = bus.rd;
    got.stalls = n;
    e = exp_q.pop_front();
    check({e.tag, "_rd"}, got.rd, e.rd);
    check({e.tag, "_stalls"}, 32'(got.stalls), 32'(e.stalls));
    @(posedge clk);
    #1;
    bus.re = 1'b0;
  endtask

  // kind: 0 sw, 1 sh, 2 sb
  task automatic do_store(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                          input int kind);
    logic [2:0] i;
    logic       mis;
    i   = addr[4:2];
    mis = (kind == 0) ? (addr[1:0] != 2'b00) : (kind == 1) ? addr[0] : 1'b0;
    if (mv[i] && mt[i] == addr[31:5] && mis) mv[i] = 1'b0;
    bus.a  = addr;
    bus.wd = wd;
    bus.sw = (kind == 0);
    bus.sh = (kind == 1);
    bus.sb = (kind == 2);
    @(negedge clk);
    check({tag, "_mem_a"}, bus.mem_a, addr);
    check({tag, "_mem_wd"}, bus.mem_wd, wd);
    check({tag, "_mem_s"}, {29'd0, bus.mem_sw, bus.mem_sh, bus.mem_sb},
          {29'd0, kind == 0, kind == 1, kind == 2});
    check({tag, "_stall"}, {31'd0, bus.stall}, 32'd0);
    @(posedge clk);
    #1;
    bus.sw = 1'b0;
    bus.sh = 1'b0;
    bus.sb = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 256; k++) ram[k] = 8'(k) ^ 8'h5A;
    {ram[3], ram[2], ram[1], ram[0]} = 32'hDEADBEEF;
    clear_model();
    bus.re = 1'b1; bus.ld_size = 2'b10; bus.sw = 1'b1; bus.sh = 1'b0; bus.sb = 1'b0;
    bus.a = 32'h0001_0000; bus.wd = 32'h1234_5678;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", {31'd0, bus.stall}, 32'd0);
    check("rst_rd", bus.rd, 32'd0);
    check("rst_mem_s", {29'd0, bus.mem_sw, bus.mem_sh, bus.mem_sb}, 32'd0);
    check_counters("rst");
    @(posedge clk);
    #1;
    rst = 1'b0; bus.re = 1'b0; bus.sw = 1'b0;

    do_load("lw_miss", 32'h0001_0000, 2'b10);
    do_load("lw_hit", 32'h0001_0000, 2'b10);
    check_counters("after_two_lw");
    do_load("lbu_hit", 32'h0001_0001, 2'b00);
    do_store("sb_hit", 32'h0001_0000, 32'h0000_0011, 2);
    do_load("lw_after_sb", 32'h0001_0000, 2'b10);
    do_store("sw_conflict", 32'h0001_0020, 32'hCAFE_F00D, 0);
    do_load("lw_old_line", 32'h0001_0000, 2'b10);
    do_load("lw_conflict_miss", 32'h0001_0020, 2'b10);
    do_load("lw_evicted", 32'h0001_0000, 2'b10);
    do_load("lhu_hit", 32'h0001_0002, 2'b01);
    check_counters("before_cross");
    do_load("lw_cross", 32'h0001_0002, 2'b10);
    check_counters("after_cross");
    do_store("sh_aligned_hit", 32'h0001_0002, 32'hABCD_7777, 1);
    do_load("lw_after_sh", 32'h0001_0000, 2'b10);
    do_store("sh_misaligned_hit", 32'h0001_0001, 32'h0000_9999, 1);
    do_load("lw_after_inval", 32'h0001_0000, 2'b10);

    // Reset asserted in the REFILL cycle must leave the line empty.
    bus.re = 1'b1; bus.a = 32'h0001_0040; bus.ld_size = 2'b10;
    @(negedge clk);
    check("pre_rst_stall", {31'd0, bus.stall}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_stall", {31'd0, bus.stall}, 32'd0);
    check("mid_rst_rd", bus.rd, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0; bus.re = 1'b0;
    clear_model();
    check_counters("after_mid_rst");
    do_load("lw_after_rst", 32'h0001_0040, 2'b10);
    do_load("lw_after_rst_hit", 32'h0001_0040, 2'b10);

    for (int it = 0; it < 60; it++) begin
      logic [31:0] addr;
      int          kind;
      addr = 32'h0001_0000 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 2) == 0) begin
        kind = int'($urandom_range(0, 2));
        if (kind == 0) addr[1:0] = 2'b00;
        if (kind == 1) addr[0] = 1'b0;
        do_store("rnd_st", addr, $urandom, kind);
      end else begin
        do_load("rnd_ld", addr, 2'($urandom_range(0, 3)));
      end
    end
    check_counters("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
